// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Purpose  : Program counter with jump/branch redirect and a halt-word stop.
//            Optional saturating retire counter: define PC_RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        branch_taken,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [29:0] C_RESET_WORD = RESET_PC[31:2];

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    // Only the word address is stored, so pc[1:0] is structurally zero.
    logic [29:0] r_pc_word;
    logic [29:0] w_pc_word_next;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_cond;
    logic        w_branch_taken;
    logic        w_update;

    assign w_pc            = {r_pc_word, 2'b00};
    assign w_pc_plus4      = w_pc + 32'd4;
    assign w_cond          = (beq & zero) | (bne & ~zero);
    assign w_branch_taken  = w_cond & ~Jump & (r_state == RUN);
    assign w_branch_target = w_pc_plus4 + (imm << 2);
    assign w_jump_target   = {w_pc_plus4[31:28], jaddr, 2'b00};
    assign w_update        = (r_state == RUN) & ~stall & (instr != HALT_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_pc_word <= C_RESET_WORD;
        end else begin
            r_state   <= w_state_next;
            r_pc_word <= w_pc_word_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_word_next = r_pc_word;
        case (r_state)
            RUN: begin
                if (w_update) begin
                    if (Jump)
                        w_pc_word_next = w_jump_target[31:2];
                    else if (w_branch_taken)
                        w_pc_word_next = w_branch_target[31:2];
                    else
                        w_pc_word_next = w_pc_plus4[31:2];
                end else if (!stall) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retired <= 32'h0;
        else if (w_update && (r_retired != 32'hFFFF_FFFF))
            r_retired <= r_retired + 32'd1;
    end

    assign retired = r_retired;
`else
    assign retired = 32'h0;
`endif

    assign pc           = w_pc;
    assign pc_plus4     = w_pc_plus4;
    assign branch_taken = w_branch_taken;
    assign halted       = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] C_HW = 32'hFFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        Jump  = 1'b0;
    logic        beq   = 1'b0;
    logic        bne   = 1'b0;
    logic        zero  = 1'b0;
    logic [31:0] imm   = 32'h0;
    logic [25:0] jaddr = 26'h0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        halted;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_ret  = 32'h0;
    bit          m_halt = 1'b0;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .Jump         (Jump),
        .beq          (beq),
        .bne          (bne),
        .zero         (zero),
        .imm          (imm),
        .jaddr        (jaddr),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_taken();
        return (beq && zero) || (bne && !zero);
    endfunction

    // Reference model: architectural rules applied once per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   = 32'h0;
            m_halt = 1'b0;
            m_ret  = 32'h0;
        end else if (!m_halt && !stall) begin
            if (instr == C_HW) begin
                m_halt = 1'b1;
            end else begin
                if (Jump)
                    m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jaddr) * 32'd4);
                else if (cond_taken())
                    m_pc = m_pc + 32'd4 + imm * 32'd4;
                else
                    m_pc = m_pc + 32'd4;
`ifdef PC_RETIRE_CNT_EN
                if (m_ret != 32'hFFFF_FFFF)
                    m_ret = m_ret + 32'd1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_pc", pc, m_pc);
            chk("cyc_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("cyc_branch_taken", {31'b0, branch_taken},
                {31'b0, (!m_halt && !Jump && cond_taken())});
            chk("cyc_halted", {31'b0, halted}, {31'b0, m_halt});
            chk("cyc_retired", retired, m_ret);
        end
    end

    task automatic set_in(input logic s, input logic j, input logic bq, input logic bn,
                          input logic z, input logic [31:0] im, input logic [25:0] ja,
                          input logic [31:0] ins);
        stall = s; Jump = j; beq = bq; bne = bn; zero = z;
        imm = im; jaddr = ja; instr = ins;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_halted", {31'b0, halted}, 32'h0);
        chk("reset_retired", retired, 32'h0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        idle();
        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        tick(); chk("seq_pc3", pc, 32'hC);
`ifdef PC_RETIRE_CNT_EN
        chk("seq_retired", retired, 32'd3);
`else
        chk("seq_retired", retired, 32'd0);
`endif

        set_in(0, 1, 0, 0, 0, 32'h0, 26'h4, 32'h0);
        tick(); chk("jump_to_10", pc, 32'h10);

        set_in(0, 0, 1, 0, 1, 32'hFFFF_FFFE, 26'h0, 32'h0);
        #1 chk("beq_taken_bt", {31'b0, branch_taken}, 32'h1);
        tick(); chk("beq_taken_pc", pc, 32'h0C);

        set_in(0, 1, 0, 0, 0, 32'h0, 26'h4, 32'h0);
        tick(); chk("jump_back_10", pc, 32'h10);

        set_in(0, 0, 0, 1, 1, 32'hFFFF_FFFE, 26'h0, 32'h0);
        #1 chk("bne_not_taken_bt", {31'b0, branch_taken}, 32'h0);
        tick(); chk("bne_not_taken_pc", pc, 32'h14);

        set_in(0, 0, 1, 1, 0, 32'h1, 26'h0, 32'h0);
        #1 chk("beq_bne_both_bt", {31'b0, branch_taken}, 32'h1);
        tick(); chk("beq_bne_both_pc", pc, 32'h1C);

        set_in(0, 1, 0, 0, 0, 32'h0, 26'h10, 32'h0);
        tick(); chk("jump_to_40", pc, 32'h40);

        idle();
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'h0);
        chk("async_reset_halted", {31'b0, halted}, 32'h0);
        chk("async_reset_retired", retired, 32'h0);
        tick();
        rst_n = 1'b1;

        set_in(0, 0, 1, 0, 1, 32'h1FFF_FFFF, 26'h0, 32'h0);
        tick(); chk("branch_to_8000", pc, 32'h8000_0000);

        set_in(0, 1, 1, 0, 1, 32'h0, 26'h10, 32'h0);
        #1 chk("jump_prio_bt", {31'b0, branch_taken}, 32'h0);
        tick(); chk("jump_prio_pc", pc, 32'h8000_0040);

        pulse_reset();
        set_in(0, 0, 1, 0, 1, 32'hFFFF_FFFE, 26'h0, 32'h0);
        tick(); chk("branch_to_top", pc, 32'hFFFF_FFFC);
        chk("top_pc_plus4", pc_plus4, 32'h0);
        idle();
        tick(); chk("wrap_pc", pc, 32'h0);

        set_in(1, 0, 0, 0, 0, 32'h0, 26'h0, C_HW);
        tick(); tick();
        chk("stall_hold_pc", pc, 32'h0);
        chk("stall_no_halt", {31'b0, halted}, 32'h0);
        set_in(0, 0, 0, 0, 0, 32'h0, 26'h0, C_HW);
        tick();
        chk("halt_entered", {31'b0, halted}, 32'h1);
        chk("halt_pc", pc, 32'h0);
        set_in(0, 1, 1, 0, 1, 32'h0, 26'h4, 32'h0);
        #1 chk("halt_bt_gated", {31'b0, branch_taken}, 32'h0);
        tick(); tick();
        chk("halt_ignore_jump", pc, 32'h0);
        chk("halt_stays", {31'b0, halted}, 32'h1);

        pulse_reset();
        chk("reset_leaves_halt", {31'b0, halted}, 32'h0);
        idle();
        tick(); chk("post_halt_run", pc, 32'h4);

`ifdef PC_RETIRE_CNT_EN
        dut.r_retired = 32'hFFFF_FFFD;
        m_ret = 32'hFFFF_FFFD;
        tick(); tick(); tick();
        chk("retired_saturate", retired, 32'hFFFF_FFFF);
`endif

        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
